// File: rtl/pc_return_stack.sv
// pc_return_stack
//   Hardware return-address stack beside the program counter. A call pushes the
//   return address; a return pops it, and the popped address is presented on
//   stack_address_o in the same cycle so the PC mux (select 3'b110) can load it
//   without extra latency. Tracks occupancy, has sticky overflow/underflow flags
//   and a synchronous flush.
//
// Ports
//   clk_i            in   1      clock, rising edge
//   reset_i          in   1      asynchronous reset, active-low
//   push_i           in   1      push ret_addr_i (call)
//   pop_i            in   1      pop top entry (return)
//   flush_i          in   1      synchronous clear of contents and flags
//   ret_addr_i       in   nat_w  address to push (caller supplies PC+1)
//   stack_address_o  out  nat_w  current top of stack, 0 when empty
//   count_o          out  cnt_w  valid entries, 0..depth
//   empty_o          out  1      count_o == 0
//   full_o           out  1      count_o == depth
//   overflow_o       out  1      sticky: push attempted while full
//   underflow_o      out  1      sticky: pop attempted while empty
//
// Handshake: push_i/pop_i/flush_i are single-cycle commands sampled on every
// rising edge; there is no back-pressure, misuse is recorded in the sticky flags.

module pc_return_stack #(
  parameter int nat_w = 16,
  parameter int depth = 8,
  localparam int cnt_w = $clog2(depth) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [nat_w-1:0] ret_addr_i,
  output logic [nat_w-1:0] stack_address_o,
  output logic [cnt_w-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int ptr_w = $clog2(depth);

  logic [nat_w-1:0] entry_q [depth];
  logic [cnt_w-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty;
  logic             full;
  logic [ptr_w-1:0] top_idx;
  logic [ptr_w-1:0] wr_idx;
  logic             wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == cnt_w'(depth));

  // count-1 truncated to the index width; only used when the stack is non-empty.
  assign top_idx = ptr_w'(count_q - cnt_w'(1));

  // A push writes the next free slot, except push+pop on a non-empty stack which
  // replaces the top in place. Push while full (without pop) is dropped.
  assign wr_en  = reset_i && !flush_i && push_i && (pop_i || !full);
  assign wr_idx = (pop_i && !empty) ? top_idx : count_q[ptr_w-1:0];

  // Entry storage is deliberately not reset; it is unreadable while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      entry_q[wr_idx] <= ret_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush_i) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (full) overflow_q <= 1'b1;
          else      count_q    <= count_q + cnt_w'(1);
        end
        2'b01: begin
          if (empty) underflow_q <= 1'b1;
          else       count_q     <= count_q - cnt_w'(1);
        end
        2'b11: begin
          // Pop on empty still records underflow, but the push half is honoured.
          if (empty) begin
            underflow_q <= 1'b1;
            count_q     <= cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stack_address_o = empty ? '0 : entry_q[top_idx];
  assign count_o         = count_q;
  assign empty_o         = empty;
  assign full_o          = full;
  assign overflow_o      = overflow_q;
  assign underflow_o     = underflow_q;

  // Unknown commands out of reset would corrupt the occupancy count silently.
  always @(posedge clk_i) begin
    if (reset_i) begin
      assert (!$isunknown({push_i, pop_i}))
        else $error("pc_return_stack: push_i/pop_i unknown while out of reset");
    end
  end

endmodule
